// File: rtl/halfband_decim2_out.sv
// halfband_decim2_out: decimate-by-2 tail of the second halfband filter.
// Keeps one sample in two, applies a saturating left shift to restore the
// headroom bit taken at the filter input, then buffers into a FWFT FIFO.
// Optional build macro HB_DECIM_SATCNT_EN adds a saturating 16-bit counter
// of saturation events on kept samples (sat_cnt).
`timescale 1ns/1ps
module halfband_decim2_out #(
  parameter int WIDTH      = 18,
  parameter int GAIN_SHIFT = 1,
  parameter int KEEP_PHASE = 0,
  parameter int DEPTH      = 4
) (
  input  logic                     sys_clk,
  input  logic                     reset_n,
  input  logic                     in_en,
  input  logic signed [WIDTH-1:0]  x_in,
  input  logic                     phase_clr,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [WIDTH-1:0]  out_data,
  output logic                     ovf,
  input  logic                     ovf_clr,
`ifdef HB_DECIM_SATCNT_EN
  output logic [$clog2(DEPTH):0]   fill,
  output logic [15:0]              sat_cnt
`else
  output logic [$clog2(DEPTH):0]   fill
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + GAIN_SHIFT;
  // Saturation bounds expressed in the widened shift domain.
  localparam logic signed [EW-1:0] MAXV = {{(GAIN_SHIFT+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(GAIN_SHIFT+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [AW:0]          FULL_LVL = (AW+1)'(DEPTH);

  // Decimation phase
  logic phase_q, phase_d;
  logic keep;

  // Gain stage
  logic signed [EW-1:0]    x_ext, x_shl;
  logic                    sat_hi, sat_lo;
  logic [WIDTH-1:0]        g_dat_q, g_dat_d;
  logic                    g_vld_q;

  // FIFO
  logic [WIDTH-1:0]        mem [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]             fill_q, fill_d;
  logic                    ovf_q, ovf_d;
  logic                    empty, full, pop, push, drop;

  // The sample in the phase_clr cycle is judged on the old phase.
  assign keep = in_en && (phase_q == KEEP_PHASE[0]);

  // Next phase: clear wins over the toggle.
  always_comb begin
    phase_d = phase_q;
    if (phase_clr)  phase_d = 1'b0;
    else if (in_en) phase_d = ~phase_q;
  end

  assign x_ext  = EW'(x_in);
  assign x_shl  = x_ext <<< GAIN_SHIFT;
  assign sat_hi = x_shl > MAXV;
  assign sat_lo = x_shl < MINV;

  // Saturated gain result.
  always_comb begin
    g_dat_d = x_shl[WIDTH-1:0];
    if (sat_hi)      g_dat_d = MAXV[WIDTH-1:0];
    else if (sat_lo) g_dat_d = MINV[WIDTH-1:0];
  end

  assign empty = (fill_q == '0);
  assign full  = (fill_q == FULL_LVL);
  assign pop   = ~empty & out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push  = g_vld_q & (~full | pop);
  assign drop  = g_vld_q & full & ~pop;

  // FIFO pointer, occupancy and overflow next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    // A fresh overflow beats a simultaneous clear.
    ovf_d = (ovf_q & ~ovf_clr) | drop;
  end

  // Control state with asynchronous reset.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= 1'b0;
      g_vld_q  <= 1'b0;
      g_dat_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      g_vld_q  <= keep;
      g_dat_q  <= g_dat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are masked by fill so it needs no reset.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr_q] <= g_dat_q;
  end

  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem[rd_ptr_q];
  assign ovf       = ovf_q;
  assign fill      = fill_q;

`ifdef HB_DECIM_SATCNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Saturating count of clipped kept samples; ovf_clr also clears it.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (ovf_clr)
      sat_cnt_d = '0;
    else if (keep && (sat_hi || sat_lo) && (sat_cnt_q != 16'hFFFF))
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) sat_cnt_q <= '0;
    else          sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_halfband_decim2_out.sv
// Scoreboard bench for halfband_decim2_out: directed vectors, expected
// outputs queued at stimulus time, popped by per-instance monitors.
`timescale 1ns/1ps
module tb_halfband_decim2_out;

  logic               sys_clk = 1'b0;
  logic               reset_n;
  // Instance 0: default parameters
  logic               in_en0, phase_clr0, out_ready0, ovf_clr0;
  logic signed [17:0] x0;
  logic               out_valid0, ovf0;
  logic signed [17:0] out_data0;
  logic [2:0]         fill0;
  // Instance 1: KEEP_PHASE=1
  logic               in_en1, phase_clr1, out_ready1, ovf_clr1;
  logic signed [17:0] x1;
  logic               out_valid1, ovf1;
  logic signed [17:0] out_data1;
  logic [2:0]         fill1;
`ifdef HB_DECIM_SATCNT_EN
  logic [15:0]        sat_cnt0, sat_cnt1;
`endif

  int checks = 0;
  int errors = 0;
  int q0[$];
  int q1[$];

  always #5 sys_clk = ~sys_clk;

  halfband_decim2_out u_dut0 (
    .sys_clk(sys_clk), .reset_n(reset_n), .in_en(in_en0), .x_in(x0),
    .phase_clr(phase_clr0), .out_ready(out_ready0), .out_valid(out_valid0),
    .out_data(out_data0), .ovf(ovf0), .ovf_clr(ovf_clr0),
`ifdef HB_DECIM_SATCNT_EN
    .fill(fill0), .sat_cnt(sat_cnt0)
`else
    .fill(fill0)
`endif
  );

  halfband_decim2_out #(.KEEP_PHASE(1)) u_dut1 (
    .sys_clk(sys_clk), .reset_n(reset_n), .in_en(in_en1), .x_in(x1),
    .phase_clr(phase_clr1), .out_ready(out_ready1), .out_valid(out_valid1),
    .out_data(out_data1), .ovf(ovf1), .ovf_clr(ovf_clr1),
`ifdef HB_DECIM_SATCNT_EN
    .fill(fill1), .sat_cnt(sat_cnt1)
`else
    .fill(fill1)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_en0 = 1'b0; in_en1 = 1'b0; phase_clr0 = 1'b0; phase_clr1 = 1'b0;
    repeat (n) tick();
  endtask

  task automatic s0(input int x, input bit en);
    x0 = 18'(x); in_en0 = en;
    tick();
  endtask

  task automatic s1(input int x, input bit en, input bit clr);
    x1 = 18'(x); in_en1 = en; phase_clr1 = clr;
    tick();
  endtask

  // Monitors: every accepted beat must match the queue head.
  always @(negedge sys_clk) begin
    if (reset_n && out_valid0 && out_ready0) begin
      if (q0.size() == 0) begin
        errors++; checks++;
        $display("FAIL dut0_unexpected: got %0d expected none", out_data0);
      end else begin
        chk("dut0_out_data", out_data0, q0.pop_front());
      end
    end
  end

  always @(negedge sys_clk) begin
    if (reset_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        errors++; checks++;
        $display("FAIL dut1_unexpected: got %0d expected none", out_data1);
      end else begin
        chk("dut1_out_data", out_data1, q1.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    in_en0 = 0; x0 = 0; phase_clr0 = 0; out_ready0 = 0; ovf_clr0 = 0;
    in_en1 = 0; x1 = 0; phase_clr1 = 0; out_ready1 = 1; ovf_clr1 = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_valid", out_valid0, 0);
    chk("rst_data",  out_data0, 0);
    chk("rst_fill",  fill0, 0);
    chk("rst_ovf",   ovf0, 0);

    // Basic decimation with 2-cycle latency
    out_ready0 = 1'b1;
    q0.push_back(200);  s0(100, 1);
    chk("lat_n1_valid", out_valid0, 0);
    s0(200, 1);
    chk("lat_n2_valid", out_valid0, 1);
    q0.push_back(600);  s0(300, 1);
    s0(400, 1);
    q0.push_back(1000); s0(500, 1);
    s0(600, 1);
    idle(4);

    // Saturation both ways
    q0.push_back(131071);  s0(70000, 1);  s0(0, 1);
    q0.push_back(-131072); s0(-70000, 1); s0(0, 1);
    idle(4);
`ifdef HB_DECIM_SATCNT_EN
    chk("sat_cnt_2", sat_cnt0, 2);
`endif

    // Overflow: fifth kept sample dropped
    out_ready0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k < 5) q0.push_back(2 * k);
      s0(k, 1); s0(0, 1);
    end
    idle(3);
    chk("ovf_fill",  fill0, 4);
    chk("ovf_flag",  ovf0, 1);
    chk("ovf_valid", out_valid0, 1);
    chk("ovf_head",  out_data0, 2);
    out_ready0 = 1'b1;
    idle(6);
    chk("drain_valid", out_valid0, 0);
    chk("drain_fill",  fill0, 0);
    chk("ovf_sticky",  ovf0, 1);
    ovf_clr0 = 1'b1; tick(); ovf_clr0 = 1'b0;
    chk("ovf_cleared", ovf0, 0);
`ifdef HB_DECIM_SATCNT_EN
    chk("sat_cnt_clr", sat_cnt0, 0);
`endif

    // Full FIFO with write and pop on the same edge
    out_ready0 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      q0.push_back(2 * k);
      s0(k, 1); s0(0, 1);
    end
    idle(3);
    chk("full_fill", fill0, 4);
    q0.push_back(18); s0(9, 1);
    out_ready0 = 1'b1;
    s0(0, 1);
    chk("fullpop_ovf",  ovf0, 0);
    chk("fullpop_fill", fill0, 4);
    idle(6);
    chk("fullpop_drain_fill",  fill0, 0);
    chk("fullpop_drain_valid", out_valid0, 0);

    // Phase control on the KEEP_PHASE=1 instance
    q1.push_back(4);  s1(1, 1, 0);
    s1(2, 1, 0);
    q1.push_back(8);  s1(3, 1, 0);
    s1(4, 1, 0);
    s1(5, 1, 0);          // phase 0, dropped
    s1(0, 0, 1);          // realign to phase 0
    s1(6, 1, 0);          // dropped after clear
    q1.push_back(14); s1(7, 1, 0);
    s1(8, 1, 0);
    q1.push_back(18); s1(9, 1, 1);   // judged on old phase 1
    s1(10, 1, 0);
    q1.push_back(22); s1(11, 1, 0);
    idle(4);

    // Asynchronous reset with three entries buffered (these are wiped)
    out_ready0 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      s0(k, 1); s0(0, 1);
    end
    idle(3);
    chk("prerst_fill", fill0, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", out_valid0, 0);
    chk("async_fill",  fill0, 0);
    chk("async_ovf",   ovf0, 0);
    chk("async_data",  out_data0, 0);
    tick();
    reset_n = 1'b1;
    out_ready0 = 1'b1;
    q0.push_back(42); s0(21, 1);
    chk("postrst_n1_valid", out_valid0, 0);
    s0(0, 1);
    chk("postrst_n2_valid", out_valid0, 1);
    idle(4);
`ifdef HB_DECIM_SATCNT_EN
    chk("postrst_sat_cnt", sat_cnt0, 0);
`endif

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
